mem_arbiter: RTL and testbench

- Shares the single data-memory datapath (the read/write port with size/sign-extend control) between two requesters: the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Holds at most one transaction in flight and sequences each access over a fixed number of cycles, then returns the data to the requester that issued it.
- Sits between the IFU/LSU and the memory block in the NPC top level.

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/mem_arb_grant.sv | 33 +++
 rtl/mem_arbiter.sv | 105 ++++++++++
 tb/tb_mem_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state, owner and load-size encodings for mem_arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;
  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;
  localparam logic [3:0] SZ_B = 4'b0001;
  localparam logic [3:0] SZ_H = 4'b0010;
  localparam logic [3:0] SZ_W = 4'b0100;
  localparam logic [3:0] SZ_D = 4'b1000;
endpackage

// File: rtl/mem_arb_grant.sv
// mem_arb_grant: IFU/LSU grant, fixed LSU priority or round-robin under MEM_ARBITER_RR_EN
module mem_arb_grant
  import mem_arb_pkg::*;
(
`ifdef MEM_ARBITER_RR_EN
  input  logic clock,
  input  logic reset,
`endif
  input  logic en,
  input  logic ifu_valid,
  input  logic lsu_valid,
  output logic ifu_grant,
  output logic lsu_grant
);
`ifdef MEM_ARBITER_RR_EN
  logic last_grant;
  // remember who won the most recent accept so the other side wins the next tie
  always_ff @(posedge clock)
    if (reset) last_grant <= OWN_IFU;
    else if (ifu_grant | lsu_grant) last_grant <= lsu_grant;
  // tie goes to the requester not granted last
  always_comb begin
    lsu_grant = en & lsu_valid & (~ifu_valid | (last_grant == OWN_IFU));
    ifu_grant = en & ifu_valid & ~lsu_grant;
  end
`else
  // LSU always wins a tie
  always_comb begin
    lsu_grant = en & lsu_valid;
    ifu_grant = en & ifu_valid & ~lsu_valid;
  end
`endif
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: one-in-flight IFU/LSU sharing of the data-memory port (round-robin with MEM_ARBITER_RR_EN)
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LATENCY = 1,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_resp_valid,
  output logic [DATA_W-1:0] ifu_rdata,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic              lsu_we,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [3:0]        lsu_wmask,
  input  logic [3:0]        lsu_read_size,
  input  logic              lsu_zero_extends,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic [3:0]        mem_wmask,
  output logic [3:0]        mem_read_size,
  output logic              mem_zero_extends,
  input  logic [DATA_W-1:0] mem_read_data
);
  state_t state, state_n;
  logic owner, we, zext, idle, access, last, accept;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [3:0] wmask, size, cnt;

  assign idle   = state == IDLE;
  assign access = state == ACCESS;
  assign last   = cnt == 4'd0;
  assign accept = ifu_req_ready | lsu_req_ready;

  mem_arb_grant u_grant (
`ifdef MEM_ARBITER_RR_EN
    .clock     (clock),
    .reset     (reset),
`endif
    .en        (idle),
    .ifu_valid (ifu_req_valid),
    .lsu_valid (lsu_req_valid),
    .ifu_grant (ifu_req_ready),
    .lsu_grant (lsu_req_ready)
  );

  assign mem_addr         = addr;
  assign mem_write_data   = wdata;
  assign mem_wmask        = wmask;
  assign mem_read_size    = size;
  assign mem_zero_extends = zext;

  // state register
  always_ff @(posedge clock)
    if (reset) state <= IDLE;
    else state <= state_n;

  // next state and strobes; a store writes only on its final cycle so memory sees one write edge
  always_comb begin
    state_n        = idle ? (accept ? ACCESS : IDLE) : access ? (last ? RESP : ACCESS) : IDLE;
    mem_read_en    = access & ~we;
    mem_write_en   = access & we & last;
    ifu_resp_valid = (state == RESP) & (owner == OWN_IFU);
    lsu_resp_valid = (state == RESP) & (owner == OWN_LSU);
  end

  // latch the accepted request, count down the access, capture the result for its owner
  always_ff @(posedge clock)
    if (reset) begin
      owner     <= OWN_IFU;
      we        <= 1'b0;
      zext      <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      wmask     <= '0;
      size      <= '0;
      cnt       <= '0;
      ifu_rdata <= '0;
      lsu_rdata <= '0;
    end else begin
      if (accept) begin
        owner <= lsu_req_ready ? OWN_LSU : OWN_IFU;
        we    <= lsu_req_ready & lsu_we;
        zext  <= lsu_req_ready ? lsu_zero_extends : 1'b1;
        addr  <= lsu_req_ready ? lsu_addr : ifu_addr;
        wdata <= lsu_req_ready ? lsu_wdata : '0;
        wmask <= lsu_req_ready ? lsu_wmask : 4'b0000;
        size  <= lsu_req_ready ? lsu_read_size : SZ_W;
        cnt   <= 4'(LATENCY - 1);
      end else if (access && !last) cnt <= cnt - 4'd1;
      if (access && last && owner == OWN_LSU) lsu_rdata <= we ? '0 : mem_read_data;
      if (access && last && owner == OWN_IFU) ifu_rdata <= mem_read_data;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter at LATENCY=3 (dut) and LATENCY=1 (dut1)
module tb_mem_arbiter;
`ifdef MEM_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clock = 1'b0;
  logic reset;
  logic ifu_req_valid, lsu_req_valid, lsu_we, lsu_zero_extends;
  logic [63:0] ifu_addr, lsu_addr, lsu_wdata, mem_read_data;
  logic [3:0] lsu_wmask, lsu_read_size;
  logic ifu_req_ready, ifu_resp_valid, lsu_req_ready, lsu_resp_valid;
  logic mem_read_en, mem_write_en, mem_zero_extends;
  logic [63:0] ifu_rdata, lsu_rdata, mem_addr, mem_write_data;
  logic [3:0] mem_wmask, mem_read_size;
  logic ifu_req_ready_1, ifu_resp_valid_1, lsu_req_ready_1, lsu_resp_valid_1;
  logic mem_read_en_1, mem_write_en_1, mem_zero_extends_1;
  logic [63:0] ifu_rdata_1, lsu_rdata_1, mem_addr_1, mem_write_data_1;
  logic [3:0] mem_wmask_1, mem_read_size_1;
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mem_arbiter #(.LATENCY(3)) dut (
    .clock(clock), .reset(reset),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_we(lsu_we),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_read_size(lsu_read_size), .lsu_zero_extends(lsu_zero_extends),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_wmask(mem_wmask), .mem_read_size(mem_read_size),
    .mem_zero_extends(mem_zero_extends), .mem_read_data(mem_read_data)
  );

  mem_arbiter #(.LATENCY(1)) dut1 (
    .clock(clock), .reset(reset),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready_1), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid_1), .ifu_rdata(ifu_rdata_1),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready_1), .lsu_we(lsu_we),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_read_size(lsu_read_size), .lsu_zero_extends(lsu_zero_extends),
    .lsu_resp_valid(lsu_resp_valid_1), .lsu_rdata(lsu_rdata_1),
    .mem_read_en(mem_read_en_1), .mem_write_en(mem_write_en_1), .mem_addr(mem_addr_1),
    .mem_write_data(mem_write_data_1), .mem_wmask(mem_wmask_1), .mem_read_size(mem_read_size_1),
    .mem_zero_extends(mem_zero_extends_1), .mem_read_data(mem_read_data)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; lsu_we = 1'b0; lsu_zero_extends = 1'b0;
    ifu_addr = '0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0; lsu_read_size = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    mem_read_data = '0;
    do_reset();
    #1;
    chk("rst_ctl", {ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid, mem_read_en, mem_write_en}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_bus", {mem_read_size, mem_wmask, mem_zero_extends}, 0);
    chk("rst_rdata", ifu_rdata | lsu_rdata | mem_write_data, 0);

    // IFU read on the LATENCY=1 instance
    @(negedge clock);
    ifu_req_valid = 1'b1; ifu_addr = 64'h8000_0000; mem_read_data = 64'h0000_0000_0010_0073;
    #1 chk("t1_ready", ifu_req_ready_1, 1);
    @(negedge clock);
    ifu_req_valid = 1'b0; ifu_addr = 64'h1234;
    #1 chk("t1_ren", mem_read_en_1, 1);
    chk("t1_addr", mem_addr_1, 64'h8000_0000);
    chk("t1_size", {mem_read_size_1, mem_zero_extends_1}, 5'b0100_1);
    chk("t1_noresp", ifu_resp_valid_1, 0);
    @(negedge clock);
    #1 chk("t1_resp", ifu_resp_valid_1, 1);
    chk("t1_rdata", ifu_rdata_1, 64'h10_0073);
    chk("t1_ren_off", mem_read_en_1, 0);
    @(negedge clock);
    #1 chk("t1_pulse", ifu_resp_valid_1, 0);
    chk("t1_hold", ifu_rdata_1, 64'h10_0073);

    // LSU signed byte load, LATENCY=3
    do_reset();
    @(negedge clock);
    lsu_req_valid = 1'b1; lsu_we = 1'b0; lsu_addr = 64'h8000_2003;
    lsu_read_size = 4'b0001; lsu_zero_extends = 1'b0; mem_read_data = 64'hFFFF_FFFF_FFFF_FF80;
    #1 chk("ld_ready", {lsu_req_ready, ifu_req_ready}, 2'b10);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      if (k == 1) begin
        lsu_req_valid = 1'b0; lsu_read_size = 4'b1000; lsu_zero_extends = 1'b1; lsu_addr = 64'h0;
      end
      #1 chk("ld_ren", mem_read_en, k <= 3);
      chk("ld_resp", lsu_resp_valid, k == 4);
      if (k <= 3) chk("ld_size", {mem_read_size, mem_zero_extends}, 5'b0001_0);
      if (k <= 3) chk("ld_addr", mem_addr, 64'h8000_2003);
      if (k >= 4) chk("ld_rdata", lsu_rdata, 64'hFFFF_FFFF_FFFF_FF80);
    end

    // LSU store, LATENCY=3; store response clears lsu_rdata
    @(negedge clock);
    lsu_req_valid = 1'b1; lsu_we = 1'b1; lsu_addr = 64'h8000_1000;
    lsu_wdata = 64'hDEAD_BEEF; lsu_wmask = 4'b1111;
    #1 chk("st_ready", lsu_req_ready, 1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      if (k == 1) begin
        lsu_req_valid = 1'b0; lsu_we = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;
      end
      #1 chk("st_wen", mem_write_en, k == 3);
      chk("st_resp", lsu_resp_valid, k == 4);
      if (k <= 3) chk("st_bus", {mem_addr, mem_write_data, mem_wmask, mem_read_en}, {64'h8000_1000, 64'hDEAD_BEEF, 4'b1111, 1'b0});
      if (k == 4) chk("st_rdata", lsu_rdata, 0);
    end

    // collisions
    do_reset();
    @(negedge clock);
    lsu_req_valid = 1'b1; lsu_addr = 64'hA000; ifu_req_valid = 1'b1; ifu_addr = 64'hB000;
    #1 chk("c1_grant", {lsu_req_ready, ifu_req_ready}, 2'b10);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clock);
      if (k == 1) lsu_req_valid = 1'b0;
      if (k == 6) ifu_req_valid = 1'b0;
      #1 chk("c1_ifu_ready", ifu_req_ready, k == 5);
      chk("c1_lsu_resp", lsu_resp_valid, k == 4);
      chk("c1_ifu_resp", ifu_resp_valid, k == 9);
      if (k >= 6 && k <= 8) chk("c1_ifu_addr", mem_addr, 64'hB000);
    end
    @(negedge clock);
    lsu_req_valid = 1'b1; ifu_req_valid = 1'b1;
    #1 chk("c2_grant", {lsu_req_ready, ifu_req_ready}, 2'b10);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      if (k == 1) begin lsu_req_valid = 1'b0; ifu_req_valid = 1'b0; end
      #1 chk("c2_resp", lsu_resp_valid, k == 4);
    end
    @(negedge clock);
    lsu_req_valid = 1'b1; ifu_req_valid = 1'b1;
    #1 chk("c3_grant", {lsu_req_ready, ifu_req_ready}, RR ? 2'b01 : 2'b10);
    @(negedge clock);
    idle_inputs();

    // reset during a store's ACCESS at cnt=2
    do_reset();
    @(negedge clock);
    lsu_req_valid = 1'b1; lsu_we = 1'b1; lsu_addr = 64'h8000_3000; lsu_wdata = 64'h55; lsu_wmask = 4'b0011;
    #1 chk("ra_ready", lsu_req_ready, 1);
    @(negedge clock);
    lsu_req_valid = 1'b0; reset = 1'b1;
    #1 chk("ra_wen0", mem_write_en, 0);
    @(negedge clock);
    reset = 1'b0;
    #1 chk("ra_ctl", {ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid, mem_read_en, mem_write_en}, 0);
    chk("ra_bus", {mem_addr, mem_write_data, mem_wmask}, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      #1 chk("ra_quiet", {mem_write_en, lsu_resp_valid}, 0);
    end
    @(negedge clock);
    ifu_req_valid = 1'b1;
    #1 chk("ra_idle", ifu_req_ready, 1);
    @(negedge clock);
    idle_inputs();

    // back-to-back IFU with valid held and address changing every cycle
    do_reset();
    for (int k = 0; k < 15; k++) begin
      @(negedge clock);
      ifu_req_valid = 1'b1; ifu_addr = 64'h1000 + 64'(4 * k);
      #1 chk("bb_ready", ifu_req_ready, (k % 5) == 0);
      chk("bb_resp", ifu_resp_valid, (k % 5) == 4);
      if ((k % 5) != 0 && (k % 5) != 4) chk("bb_addr", mem_addr, 64'h1000 + 64'(4 * (k - k % 5)));
    end
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
